lut_neuron_array_rt: RTL
========================

# lut_neuron_array_rt

Runtime-programmable, pipelined array of NUM_NEURONS truth-table neurons for the layer datapath of the quantised classifier. Each neuron maps a FAN_IN×IN_BITS input vector to an OUT_BITS output through a writable table instead of a fixed case ROM, so retrained tables load without resynthesis. It sits between the input quantiser (or the previous layer) and the next layer, with valid/ready on both sides and a separate configuration port for table load and readback.

## Interface
- FAN_IN, 3, inputs per neuron
- IN_BITS, 2, bits per input
- OUT_BITS, 2, bits per neuron output
- NUM_NEURONS, 4, neurons (channels) in the array
- Derived: A = FAN_IN*IN_BITS (table address width), DEPTH = 2^A, NW = max(1, clog2(NUM_NEURONS))

- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input vector valid
- in_ready  out  1  array can accept input this cycle
- in_data  in  NUM_NEURONS*A  neuron n address at bits [n*A +: A]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  NUM_NEURONS*OUT_BITS  neuron n output at [n*OUT_BITS +: OUT_BITS]
- cfg_we  in  1  table write strobe
- cfg_re  in  1  table readback strobe
- cfg_neuron  in  NW  target neuron
- cfg_addr  in  A  target table entry
- cfg_wdata  in  OUT_BITS  write data
- cfg_rdata  out  OUT_BITS  readback data
- cfg_rvalid  out  1  readback data valid (one-cycle pulse)

## Operation
- Table: NUM_NEURONS×DEPTH entries of OUT_BITS; address = neuron input slice as unsigned (bit A-1 MSB). Entry value is the neuron output; no arithmetic.
- Reset (rst_n low, async): all table entries 0, stage valids 0, out_data 0, cfg_rdata 0, cfg_rvalid 0; in_ready 1 after release.
- Two-stage pipeline:
  - S1: captures in_data when in_valid && in_ready.
  - S2: registers per-neuron table lookup of S1 address; drives out_data/out_valid.
  - s2_adv = !out_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv (combinational from out_ready, no extra registered state).
  - out_data held stable while out_valid && !out_ready.
- Config write: cfg_we with cfg_neuron < NUM_NEURONS writes cfg_wdata into entry at clock edge. cfg_neuron >= NUM_NEURONS: write ignored.
- Config read: cfg_re registers entry into cfg_rdata, pulses cfg_rvalid next cycle; out-of-range neuron returns 0 with cfg_rvalid still pulsed.
- cfg_we && cfg_re same cycle, same entry: readback returns old value.
- Write colliding with S1→S2 lookup of same entry in same cycle: lookup uses old value; new value visible to lookups from next cycle.
- Config port never stalls the datapath; both operate concurrently.

## Timing
- Latency in_valid&&in_ready → out_valid: 2 cycles. Throughput 1 vector/cycle with out_ready held high.
- Readback latency: 1 cycle.
- Backpressure: with out_ready low, up to 2 vectors held (S1, S2); in_ready falls the cycle both are full; no loss, no duplication.
- Reset mid-stream: in-flight vectors discarded, tables cleared; no out_valid until new input accepted.
- Table reset to all-zero is required; software reloads after every reset.

## Test plan
- Reset: drive rst_n low mid-stream with out_valid=1 → out_valid, cfg_rvalid, out_data drop to 0 immediately; readback of neuron 2 addr 6'h2A returns 2'b00.
- Load/eval: neuron 0 table loaded with entry 6'b001000=2'b11, 6'b110000=2'b01; in_data neuron0 = 6'b001000 then 6'b110000 back-to-back, out_ready=1 → out_data[1:0]=2'b11 at cycle+2, 2'b01 at cycle+3.
- Backpressure: stream 8 vectors with out_ready toggled 1,0,0,1,… → all 8 outputs in order, each matching table model, in_ready low only when S1 and S2 both hold data.
- Collision: write neuron 1 addr 6'h15 = 2'b10 (old 2'b01) in the same cycle S1 holds 6'h15 → output 2'b01; next lookup of 6'h15 → 2'b10.
- Readback: cfg_we and cfg_re same cycle, same entry (old 2'b00, new 2'b11) → cfg_rdata 2'b00; repeat read → 2'b11; cfg_neuron=NUM_NEURONS read → 2'b00 with cfg_rvalid=1, table unchanged.
- Params: FAN_IN=4, IN_BITS=2, OUT_BITS=3, NUM_NEURONS=8 → random load of all 8×256 entries, 1000 random vectors, outputs match reference model.

Source files
------------

// File: rtl/lut_neuron_array_rt.sv
// lut_neuron_array_rt
//   Runtime-programmable array of truth-table neurons with a two-stage
//   valid/ready pipeline. Each neuron looks up its FAN_IN*IN_BITS input
//   slice in its own writable table and returns an OUT_BITS result.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_data holds neuron n address at [n*A +: A]
//   out_valid/out_ready   output handshake; out_data holds neuron n result at [n*OUT_BITS +: OUT_BITS]
//   cfg_we/cfg_re         table write / readback strobes
//   cfg_neuron, cfg_addr  target table entry; out-of-range neurons are ignored on write
//   cfg_wdata             write data
//   cfg_rdata/cfg_rvalid  readback data, valid for one cycle after cfg_re
module lut_neuron_array_rt #(
  parameter int FAN_IN      = 3,
  parameter int IN_BITS     = 2,
  parameter int OUT_BITS    = 2,
  parameter int NUM_NEURONS = 4,
  localparam int A     = FAN_IN * IN_BITS,
  localparam int DEPTH = 2 ** A,
  localparam int NW    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_NEURONS*A-1:0]        in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
  input  logic                            cfg_we,
  input  logic                            cfg_re,
  input  logic [NW-1:0]                   cfg_neuron,
  input  logic [A-1:0]                    cfg_addr,
  input  logic [OUT_BITS-1:0]             cfg_wdata,
  output logic [OUT_BITS-1:0]             cfg_rdata,
  output logic                            cfg_rvalid
);

  localparam logic [NW:0] NUM_NEURONS_W = (NW + 1)'(NUM_NEURONS);

  logic [OUT_BITS-1:0]             tbl_q [NUM_NEURONS][DEPTH];
  logic [OUT_BITS-1:0]             tbl_d [NUM_NEURONS][DEPTH];
  logic                            s1_valid_q, s1_valid_d;
  logic [NUM_NEURONS*A-1:0]        s1_data_q, s1_data_d;
  logic                            out_valid_q, out_valid_d;
  logic [NUM_NEURONS*OUT_BITS-1:0] out_data_q, out_data_d;
  logic [NUM_NEURONS*OUT_BITS-1:0] lookup;
  logic [OUT_BITS-1:0]             cfg_rdata_q, cfg_rdata_d;
  logic                            cfg_rvalid_q, cfg_rvalid_d;
  logic                            s2_adv, s1_adv, cfg_hit;

  // Guards non-power-of-two arrays, where cfg_neuron can name a missing neuron.
  assign cfg_hit = {1'b0, cfg_neuron} < NUM_NEURONS_W;

  // Pipeline control: a stage advances when the stage after it can take its data.
  // NOTE: combinational blocks use blocking assignments and give every output a
  // default first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    s2_adv      = !out_valid_q || out_ready;
    s1_adv      = !s1_valid_q || s2_adv;
    s1_valid_d  = s1_adv ? in_valid : s1_valid_q;
    s1_data_d   = (s1_adv && in_valid) ? in_data : s1_data_q;
    out_valid_d = s2_adv ? s1_valid_q : out_valid_q;

    // Lookups read the registered table, so a same-cycle write is seen only
    // by lookups from the next cycle on.
    lookup = '0;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      lookup[n*OUT_BITS +: OUT_BITS] = tbl_q[n][s1_data_q[n*A +: A]];
    end
    out_data_d = (s2_adv && s1_valid_q) ? lookup : out_data_q;
  end

  // Configuration port: independent of the datapath handshake.
  always_comb begin
    tbl_d = tbl_q;
    if (cfg_we && cfg_hit) begin
      tbl_d[cfg_neuron][cfg_addr] = cfg_wdata;
    end
    cfg_rvalid_d = cfg_re;
    cfg_rdata_d  = cfg_rdata_q;
    if (cfg_re) begin
      // Reads the pre-write value when a write hits the same entry.
      cfg_rdata_d = cfg_hit ? tbl_q[cfg_neuron][cfg_addr] : '0;
    end
  end

  // NOTE: the table is cleared by reset, so it is built from resettable flops
  // rather than an inferred RAM; all state updates use non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_q        <= '{default: '0};
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      cfg_rdata_q  <= '0;
      cfg_rvalid_q <= 1'b0;
    end else begin
      tbl_q        <= tbl_d;
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      cfg_rdata_q  <= cfg_rdata_d;
      cfg_rvalid_q <= cfg_rvalid_d;
    end
  end

  assign in_ready   = s1_adv;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign cfg_rdata  = cfg_rdata_q;
  assign cfg_rvalid = cfg_rvalid_q;

endmodule
